// File: rtl/background_addr_gen.sv
// Background-tile ROM address generator: counter-based raster tracking, SCALE downsampling,
// per-frame wrapped horizontal scroll and frame-latched background select, two-stage pipeline.
module background_addr_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SCALE    = 10,
  parameter int TILE_W   = 64,
  parameter int TILE_H   = 48,
  parameter int NUM_BG   = 5,
  parameter int BG_W     = 5,
  parameter int SCROLL_W = 6,
  parameter int AW       = 14
) (
  input  logic                iVGA_CLK,
  input  logic                iRST_n,
  input  logic                frame_start,
  input  logic                pix_en,
  input  logic [BG_W-1:0]     bg_sel_next,
  input  logic [SCROLL_W-1:0] scroll_next,
  output logic [AW-1:0]       background_ADDR,
  output logic                addr_valid,
  output logic                frame_done,
  output logic [BG_W-1:0]     cur_bg
);

  localparam int SXW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int PXW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int PYW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int TXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int TYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam logic [31:0] TILE_W32  = 32'(TILE_W);
  localparam logic [31:0] BG_STRIDE = 32'(TILE_W * TILE_H);

  logic [SXW-1:0]      sx_reg, sx_cur, sx_next;
  logic [PXW-1:0]      px_reg, px_cur, px_next;
  logic [TXW-1:0]      tx_reg, tx_cur, tx_next;
  logic [SXW-1:0]      sy_reg, sy_cur, sy_next;
  logic [PYW-1:0]      py_reg, py_cur, py_next;
  logic [TYW-1:0]      ty_reg, ty_cur, ty_next;
  logic [BG_W-1:0]     bg_reg, bg_cur;
  logic [SCROLL_W-1:0] scroll_reg, scroll_cur;
  logic                line_end, frame_end;
  logic [31:0]         col_sum, col_wrap;

  logic [TXW-1:0]      col1_reg;
  logic [TYW-1:0]      ty1_reg;
  logic [BG_W-1:0]     bg1_reg;
  logic                v1_reg, last1_reg;
  logic [31:0]         addr_sum;

  // frame_start acts on the pixel issued in the same cycle, so use the cleared/latched view
  always_comb begin
    sx_cur = frame_start ? '0 : sx_reg;
    px_cur = frame_start ? '0 : px_reg;
    tx_cur = frame_start ? '0 : tx_reg;
    sy_cur = frame_start ? '0 : sy_reg;
    py_cur = frame_start ? '0 : py_reg;
    ty_cur = frame_start ? '0 : ty_reg;
    bg_cur = bg_reg;
    scroll_cur = scroll_reg;
    if (frame_start) begin
      bg_cur     = (32'(bg_sel_next) < 32'(NUM_BG)) ? bg_sel_next : '0;
      scroll_cur = (32'(scroll_next) < TILE_W32) ? scroll_next : '0;
    end
  end

  assign line_end  = (px_cur == PXW'(H_ACTIVE - 1));
  assign frame_end = line_end && (py_cur == PYW'(V_ACTIVE - 1));

  // tx and scroll are both below TILE_W, so one conditional subtract completes the modulo
  assign col_sum  = 32'(tx_cur) + 32'(scroll_cur);
  assign col_wrap = (col_sum >= TILE_W32) ? (col_sum - TILE_W32) : col_sum;

  always_comb begin
    sx_next = sx_cur;
    px_next = px_cur;
    tx_next = tx_cur;
    sy_next = sy_cur;
    py_next = py_cur;
    ty_next = ty_cur;
    if (pix_en) begin
      if (line_end) begin
        sx_next = '0;
        px_next = '0;
        tx_next = '0;
        if (frame_end) begin
          sy_next = '0;
          py_next = '0;
          ty_next = '0;
        end else begin
          py_next = py_cur + PYW'(1);
          if (sy_cur == SXW'(SCALE - 1)) begin
            sy_next = '0;
            ty_next = ty_cur + TYW'(1);
          end else begin
            sy_next = sy_cur + SXW'(1);
          end
        end
      end else begin
        px_next = px_cur + PXW'(1);
        if (sx_cur == SXW'(SCALE - 1)) begin
          sx_next = '0;
          tx_next = tx_cur + TXW'(1);
        end else begin
          sx_next = sx_cur + SXW'(1);
        end
      end
    end
  end

  assign addr_sum = 32'(col1_reg) + 32'(ty1_reg) * TILE_W32 + 32'(bg1_reg) * BG_STRIDE;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sx_reg          <= '0;
      px_reg          <= '0;
      tx_reg          <= '0;
      sy_reg          <= '0;
      py_reg          <= '0;
      ty_reg          <= '0;
      bg_reg          <= '0;
      scroll_reg      <= '0;
      col1_reg        <= '0;
      ty1_reg         <= '0;
      bg1_reg         <= '0;
      v1_reg          <= 1'b0;
      last1_reg       <= 1'b0;
      background_ADDR <= '0;
      addr_valid      <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      sx_reg     <= sx_next;
      px_reg     <= px_next;
      tx_reg     <= tx_next;
      sy_reg     <= sy_next;
      py_reg     <= py_next;
      ty_reg     <= ty_next;
      bg_reg     <= bg_cur;
      scroll_reg <= scroll_cur;
      v1_reg     <= pix_en;
      last1_reg  <= pix_en & frame_end;
      if (pix_en) begin
        col1_reg <= col_wrap[TXW-1:0];
        ty1_reg  <= ty_cur;
        bg1_reg  <= bg_cur;
      end
      addr_valid <= v1_reg;
      frame_done <= v1_reg & last1_reg;
      if (v1_reg) begin
        background_ADDR <= addr_sum[AW-1:0];
      end
    end
  end

  assign cur_bg = bg_reg;

endmodule
